vga_timing_gen: RTL

- Parametrised VGA/video timing generator; successor to the fixed 640x480 sync timer.
- Generates hsync, vsync, activevideo and pixel coordinates x/y for any mode. Porches, sync widths, sync polarity and pixel-clock divide ratio are all parameters.
- Adds a pixel-enable tick, a freeze input, and one-cycle line/frame start strobes.
- Sits between the system clock and the pixel/character renderers and display drivers.

---
 rtl/vga_timing_gen.sv | 76 +++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing with pixel-clock divider, freeze and line/frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int XBITS    = 10,
    parameter int YBITS    = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             activevideo,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || XBITS < $clog2(H_TOTAL) || YBITS < $clog2(V_TOTAL)) begin : g_bad
        $error("vga_timing_gen: CLK_DIV must be >= 1 and XBITS/YBITS wide enough for the totals");
    end

    logic [DW-1:0]    div;
    logic             x_wrap, y_wrap;
    logic [XBITS-1:0] x_nxt;
    logic [YBITS-1:0] y_nxt;

    // reset_n gates the tick so CLK_DIV=1 stays silent while held in reset
    always_comb begin
        pixel_tick = enable && reset_n && div == DW'(CLK_DIV - 1);
        x_wrap     = x == XBITS'(H_TOTAL - 1);
        y_wrap     = y == YBITS'(V_TOTAL - 1);
        x_nxt      = pixel_tick ? (x_wrap ? '0 : x + 1'b1) : x;
        y_nxt      = pixel_tick && x_wrap ? (y_wrap ? '0 : y + 1'b1) : y;
    end

    // decoded outputs use the next x/y so they line up with the counter registers
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            div         <= '0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            activevideo <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= pixel_tick ? '0 : div + DW'(enable);
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= (int'(x_nxt) >= HS_START && int'(x_nxt) < HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (int'(y_nxt) >= VS_START && int'(y_nxt) < VS_END) ? VS_POL : ~VS_POL;
            activevideo <= int'(x_nxt) < H_ACTIVE && int'(y_nxt) < V_ACTIVE;
            line_start  <= pixel_tick && x_wrap;
            frame_start <= pixel_tick && x_wrap && y_wrap;
        end
endmodule
